// File: rtl/load_store_unit_if.sv
// Request and data-memory bus between the pipeline, the load/store unit and memory.
// slave is the unit's view; master is the pipeline/memory side.
interface load_store_unit_if #(
   parameter int N = 32
);
   logic         req_valid;
   logic         req_ready;
   logic         is_store;
   logic [2:0]   funct3;
   logic [N-1:0] addr;
   logic [N-1:0] store_data;
   logic [N-1:0] load_data;
   logic         done;
   logic         err;
   logic [N-1:0] mem_adr;
   logic [N-1:0] mem_write_data;
   logic         mem_write;
   logic [N-1:0] mem_read_data;

   modport slave (
      input  req_valid, is_store, funct3, addr, store_data,
      input  mem_read_data,
      output req_ready, load_data, done, err,
      output mem_adr, mem_write_data, mem_write
   );

   modport master (
      output req_valid, is_store, funct3, addr, store_data,
      output mem_read_data,
      input  req_ready, load_data, done, err,
      input  mem_adr, mem_write_data, mem_write
   );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store sequencer over a word-wide memory; sb/sh use read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to flag misaligned h/w accesses instead of aligning them.
module load_store_unit #(
   parameter int N = 32
) (
   input  logic             clk,
   input  logic             reset,
   load_store_unit_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, WRITE, DONE} state_t;

   state_t       state_q, state_d;
   logic [N-1:0] addr_q, addr_d;
   logic [2:0]   f3_q, f3_d;
   logic         st_q, st_d;
   logic [N-1:0] sdata_q, sdata_d;
   logic [N-1:0] word_q, word_d;
   logic [N-1:0] load_q, load_d;
   logic         err_q, err_d;

   logic         is_h, is_w, illegal, misalign, fault;
   logic [1:0]   off;
   logic [4:0]   sh_amt;
   logic [7:0]   rd_b;
   logic [15:0]  rd_h;
   logic [N-1:0] ext, mask, rep, merged, word_adr;

   logic         ready, done, we;
   logic [N-1:0] wdata, adr;

   assign is_h = (f3_q[1:0] == 2'b01);
   assign is_w = (f3_q[1:0] == 2'b10);

   assign illegal = (f3_q[1:0] == 2'b11)
                  | (f3_q == 3'b110)
                  | (st_q & f3_q[2]);

`ifdef LSU_MISALIGN_TRAP_EN
   assign misalign = (is_h & addr_q[0])
                   | (is_w & (addr_q[1:0] != 2'b00));
`else
   assign misalign = 1'b0;
`endif

   assign fault = illegal | misalign;

   // Low address bits below the access size are ignored when not trapping
   assign off = is_w ? 2'b00
              : is_h ? {addr_q[1], 1'b0}
              : addr_q[1:0];

   assign sh_amt   = {off, 3'b000};
   assign rd_b     = 8'(bus.mem_read_data >> sh_amt);
   assign rd_h     = 16'(bus.mem_read_data >> sh_amt);
   assign word_adr = {addr_q[N-1:2], 2'b00};

   always_comb begin
      ext = '0;
      unique case (f3_q)
         3'b000:  ext = {{(N-8){rd_b[7]}}, rd_b};
         3'b001:  ext = {{(N-16){rd_h[15]}}, rd_h};
         3'b010:  ext = bus.mem_read_data;
         3'b100:  ext = {{(N-8){1'b0}}, rd_b};
         3'b101:  ext = {{(N-16){1'b0}}, rd_h};
         default: ext = '0;
      endcase
   end

   assign mask = is_h ? (N'(16'hFFFF) << sh_amt)
                      : (N'(8'hFF) << sh_amt);
   assign rep  = is_h ? {(N/16){sdata_q[15:0]}}
                      : {(N/8){sdata_q[7:0]}};

   assign merged = (word_q & ~mask) | (rep & mask);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      f3_d    = f3_q;
      st_d    = st_q;
      sdata_d = sdata_q;
      word_d  = word_q;
      load_d  = load_q;
      err_d   = err_q;
      ready   = 1'b0;
      done    = 1'b0;
      we      = 1'b0;
      wdata   = '0;
      adr     = '0;
      unique case (state_q)
         IDLE: begin
            ready = 1'b1;
            if (bus.req_valid) begin
               addr_d  = bus.addr;
               f3_d    = bus.funct3;
               st_d    = bus.is_store;
               sdata_d = bus.store_data;
               err_d   = 1'b0;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            adr     = word_adr;
            state_d = DONE;
            if (fault) begin
               err_d  = 1'b1;
               load_d = '0;
            end else if (!st_q) begin
               load_d = ext;
            end else if (is_w) begin
               we    = 1'b1;
               wdata = sdata_q;
            end else begin
               word_d  = bus.mem_read_data;
               state_d = WRITE;
            end
         end
         WRITE: begin
            adr     = word_adr;
            we      = 1'b1;
            wdata   = merged;
            state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         f3_q    <= '0;
         st_q    <= 1'b0;
         sdata_q <= '0;
         word_q  <= '0;
         load_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         f3_q    <= f3_d;
         st_q    <= st_d;
         sdata_q <= sdata_d;
         word_q  <= word_d;
         load_q  <= load_d;
         err_q   <= err_d;
      end
   end

   assign bus.req_ready      = ready;
   assign bus.done           = done;
   assign bus.err            = done & err_q;
   assign bus.load_data      = load_q;
   assign bus.mem_write      = we;
   assign bus.mem_write_data = wdata;
   assign bus.mem_adr        = adr;
endmodule
